// File: rtl/nota_pkg.sv
// nota_pkg
// Shared definitions for the grade-classification display sequencer:
// the controller state encoding, the 7-segment patterns for each letter
// class, the grade thresholds and the grade clamp helper.
package nota_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SHOW    = 2'd1,
        AVG     = 2'd2,
        DONE    = 2'd3
    } state_t;

    // 7-segment patterns (bit 0 = segment a ... bit 6 = segment g)
    localparam logic [7:0] LETRA_A   = 8'h77;
    localparam logic [7:0] LETRA_P   = 8'h73;
    localparam logic [7:0] LETRA_F   = 8'h71;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam logic [3:0] NOTA_MAX    = 4'd10;
    localparam logic [3:0] NOTA_APROV  = 4'd7;
    localparam logic [3:0] NOTA_REPROV = 4'd4;

    // Switch values above the maximum grade are saturated, not wrapped.
    function automatic logic [3:0] clamp_grade(input logic [3:0] grade);
        return (grade > NOTA_MAX) ? NOTA_MAX : grade;
    endfunction

endpackage

// File: rtl/nota_classifier.sv
// nota_classifier
// Purely combinational mapping from a 4-bit grade to the 7-segment
// pattern of its letter class.
// Ports:
//   grade - grade to classify, 0..15 (callers pass clamped values)
//   seg   - 7-segment pattern: LETRA_A, LETRA_F or LETRA_P
module nota_classifier
    import nota_pkg::*;
(
    input  logic [3:0] grade,
    output logic [7:0] seg
);

    always_comb begin
        if (grade >= NOTA_APROV) begin
            seg = LETRA_A;
        end else if (grade < NOTA_REPROV) begin
            seg = LETRA_P;
        end else begin
            seg = LETRA_F;
        end
    end

endmodule

// File: rtl/nota_sequencer.sv
// nota_sequencer
// Collects NALUNOS grades from the switches (one per rising edge of
// 'enter'), then steps through them showing each grade's letter class on
// the 7-segment display and {index, grade} on the LEDs, HOLD_CYCLES clock
// cycles per student, and finally parks in DONE until the next press.
// Optional feature: define NOTA_AVG_EN to add a running sum and an AVG
// display step (class average) between the last SHOW entry and DONE.
// Ports:
//   clk_2   - system clock, rising edge
//   reset   - synchronous, active-high
//   nota_in - grade on the switches, 0..15 (stored clamped to 10)
//   enter   - store button, level input; only its rising edge acts
//   SEG     - 7-segment pattern
//   LED     - {index[3:0], grade[3:0]} status
//   done    - high while in DONE
module nota_sequencer
    import nota_pkg::*;
#(
    parameter int NALUNOS     = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [3:0] nota_in,
    input  logic       enter,
    output logic [7:0] SEG,
    output logic [7:0] LED,
    output logic       done
);

    localparam int IDX_W = $clog2(NALUNOS);
    localparam int DW_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NALUNOS - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [DW_W-1:0]  dwell;
    logic             enter_q;
    logic [3:0]       grade_buf [NALUNOS];

    logic             store;
    logic [3:0]       nota_clamped;
    logic [3:0]       idx_wide;
    logic [3:0]       cur_grade;
    logic [3:0]       class_in;
    logic [7:0]       class_seg;

    assign store        = enter & ~enter_q;
    assign nota_clamped = clamp_grade(nota_in);
    assign idx_wide     = 4'(idx);
    assign cur_grade    = grade_buf[idx];

`ifdef NOTA_AVG_EN
    localparam int SUM_W     = $clog2(10 * NALUNOS + 1);
    localparam int AVG_SHIFT = $clog2(NALUNOS);

    logic [SUM_W-1:0] sum;
    logic [3:0]       avg;

    assign avg      = 4'(sum >> AVG_SHIFT);
    assign class_in = (state == AVG) ? avg : cur_grade;
`else
    assign class_in = cur_grade;
`endif

    nota_classifier u_classifier (
        .grade (class_in),
        .seg   (class_seg)
    );

    // Controller: collect a batch, show each entry for HOLD_CYCLES, then
    // wait in DONE. enter_q resets high so a button still held while reset
    // is released is not mistaken for a fresh press.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state   <= COLLECT;
            idx     <= '0;
            dwell   <= '0;
            enter_q <= 1'b1;
            for (int i = 0; i < NALUNOS; i++) begin
                grade_buf[i] <= '0;
            end
`ifdef NOTA_AVG_EN
            sum     <= '0;
`endif
        end else begin
            enter_q <= enter;
            case (state)
                COLLECT: begin
                    if (store) begin
                        grade_buf[idx] <= nota_clamped;
`ifdef NOTA_AVG_EN
                        sum <= sum + SUM_W'(nota_clamped);
`endif
                        if (idx == IDX_LAST) begin
                            state <= SHOW;
                            idx   <= '0;
                            dwell <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (idx == IDX_LAST) begin
`ifdef NOTA_AVG_EN
                            state <= AVG;
`else
                            state <= DONE;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
`ifdef NOTA_AVG_EN
                AVG: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        state <= DONE;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
`endif
                DONE: begin
                    // Old grades stay in the buffer and are overwritten by
                    // the next batch; only the running sum restarts.
                    if (store) begin
                        state <= COLLECT;
                        idx   <= '0;
`ifdef NOTA_AVG_EN
                        sum   <= '0;
`endif
                    end
                end
                default: begin
                    state <= COLLECT;
                    idx   <= '0;
                    dwell <= '0;
                end
            endcase
        end
    end

    // Moore output decode of the registered state.
    always_comb begin
        SEG  = SEG_BLANK;
        LED  = 8'h00;
        done = 1'b0;
        case (state)
            COLLECT: begin
                LED = {idx_wide, 4'h0};
            end
            SHOW: begin
                SEG = class_seg;
                LED = {idx_wide, cur_grade};
            end
`ifdef NOTA_AVG_EN
            AVG: begin
                SEG = class_seg;
                LED = {4'hF, avg};
            end
`endif
            DONE: begin
                SEG  = SEG_DASH;
                done = 1'b1;
            end
            default: begin
                SEG = SEG_BLANK;
            end
        endcase
    end

endmodule

// File: doc/nota_sequencer.md
# nota_sequencer

Sequential controller for the board's grade-classification display. It collects `NALUNOS` student grades entered one at a time on the switches, stores them, then steps through them automatically. Each stored grade is shown as its letter class on the 7-segment display, with the student index on the LEDs. It sits between the switch inputs and the `SEG`/`LED` outputs of the board top and owns both displays.

## Interface
Parameters:
- `NALUNOS`, 4: number of students per batch; power of two, 2..16.
- `HOLD_CYCLES`, 2: clock cycles each result stays on the display; ≥1.

Ports:
- `clk_2`, in, 1: single system clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `nota_in`, in, 4: grade currently on the switches, 0..15.
- `enter`, in, 1: level-sensitive store button; only a rising edge acts.
- `SEG`, out, 8: 7-segment pattern.
- `LED`, out, 8: `{index[3:0], grade[3:0]}` status.
- `done`, out, 1: high while in `DONE`.

## Operation
- All outputs are Moore decodes of registered state; no combinational input-to-output path.
- Edge detect:
  - `enter_q` registers `enter`.
  - Store event = `enter & ~enter_q`.
- Grade clamp: a grade >10 is stored as 10.
- Letter classification:
  - grade ≥7 → `LETRA_A` 8'h77.
  - grade <4 → `LETRA_P` 8'h73.
  - otherwise → `LETRA_F` 8'h71.
- State `COLLECT` (reset state):
  - Outputs: `SEG`=8'h00, `LED`=`{idx,4'h0}`, `done`=0.
  - On a store event: write the clamped `nota_in` to `buf[idx]`.
  - If `idx`==`NALUNOS`-1: go to `SHOW` with `idx`=0 and `dwell`=0. Otherwise increment `idx`.
- State `SHOW`:
  - Outputs: `SEG`=letter(`buf[idx]`), `LED`=`{idx,buf[idx]}`.
  - `dwell` counts 0..`HOLD_CYCLES`-1.
  - At the last dwell cycle: if `idx`==`NALUNOS`-1 go to `AVG` (macro on) or `DONE`. Otherwise increment `idx` and clear `dwell`.
  - Store events are ignored.
- State `DONE`:
  - Outputs: `SEG`=8'h40 (dash), `LED`=8'h00, `done`=1.
  - A store event goes to `COLLECT` with `idx`=0. The buffer is not cleared; it is overwritten on the next batch.
- Reset:
  - `state`=`COLLECT`, `idx`=0, `dwell`=0, all `buf` entries=0.
  - `enter_q`=1, so a button still held as reset releases does not register as a store.
  - Outputs after reset: `SEG`=8'h00, `LED`=8'h00, `done`=0.
- Reset mid-operation, from any state: the next edge gives the reset state. No partial batch is retained.

## Timing
- A store event sampled at edge t: the buffer write, `idx` update and state change all happen at t. Outputs reflect the new state immediately after t.
- Each `SHOW` entry lasts exactly `HOLD_CYCLES` cycles. The full display sequence lasts `NALUNOS`×`HOLD_CYCLES` cycles, plus `HOLD_CYCLES` when `AVG` is compiled in.
- Holding `enter` high for any number of cycles produces one store.
- Reset and a store event in the same cycle: reset wins.

## Configuration
- `NOTA_AVG_EN` defined:
  - A running sum register (width `$clog2(10*NALUNOS+1)`) accumulates the clamped grades in `COLLECT` and is cleared on `COLLECT` entry and on reset.
  - An `AVG` state follows `SHOW` for `HOLD_CYCLES` cycles, then goes to `DONE`.
  - In `AVG`: `avg` = sum >> `$clog2(NALUNOS)` (truncating), `SEG`=letter(`avg`), `LED`=`{4'hF,avg}`.
- `NOTA_AVG_EN` undefined: no sum logic, no `AVG` state; `SHOW` goes directly to `DONE`.

## Structure
- Package `nota_pkg` holds:
  - State enum `COLLECT`/`SHOW`/`AVG`/`DONE`.
  - `LETRA_A`/`LETRA_P`/`LETRA_F` and the dash code.
  - `NOTA_MAX`=10 and thresholds `NOTA_APROV`=7, `NOTA_REPROV`=4.
- Sub-module `nota_classifier`: combinational 4-bit grade → 8-bit segment pattern. Instantiate it once, fed by a mux of `buf[idx]` and `avg`.

## Test plan
All scenarios use `NALUNOS`=4, `HOLD_CYCLES`=2.
- Store 8,3,5,7 → `SEG` shows 77,77,73,73,71,71,77,77; `LED` shows 08,08,13,13,25,25,37,37; then `done`=1 and `SEG`=40.
- Boundary grades 7,6,4,3 → A, F, F, P.
- Clamp: `nota_in`=15 is stored as 10, so `LED`[3:0]=A and `SEG`=77.
- `enter` held high for 5 cycles in `COLLECT` → `idx` advances by exactly 1. `enter` held high through reset release → no store.
- Reset asserted during the second `SHOW` entry → next cycle `SEG`=00, `LED`=00, `done`=0; a new batch of 4 grades completes normally.
- `NOTA_AVG_EN` defined, grades 8,3,5,7 (sum 23, avg 5) → after `SHOW`, 2 cycles of `SEG`=71, `LED`=F5; then `DONE`.
